// File: rtl/des_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : des_io_pkg
// Description : Shared widths and serializer state type for the DES IO path.
// Revision    : 1.0
// ============================================================================
package des_io_pkg;

    localparam int BLOCK_W         = 64;
    localparam int BYTE_W          = 8;
    localparam int BYTES_PER_BLOCK = 8;
    localparam int IDX_W           = $clog2(BYTES_PER_BLOCK);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/des_block_fifo.sv
`default_nettype none
// ============================================================================
// Module      : des_block_fifo
// Description : Synchronous DEPTH x 64-bit block FIFO with wrapping pointers.
// Revision    : 1.0
// ============================================================================
module des_block_fifo
    import des_io_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic [BLOCK_W-1:0]           i_data,
    input  logic                         i_pop,
    output logic [BLOCK_W-1:0]           o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_level
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int LVL_W  = $clog2(DEPTH + 1);

    logic [BLOCK_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic               w_wr_en;
    logic               w_rd_en;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_rd_en = i_pop && !o_empty;
    assign w_wr_en = i_push && (!o_full || w_rd_en);
    assign o_data  = r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign o_level = r_level;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_wr_en && !w_rd_en) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_rd_en && !w_wr_en) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/des_out_serializer.sv
`default_nettype none
// ============================================================================
// Module      : des_out_serializer
// Description : Buffers DES result blocks and streams them as valid/ready bytes.
// Revision    : 1.0
// ============================================================================
module des_out_serializer
    import des_io_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [BLOCK_W-1:0]           i_block,
    input  logic                         i_dv,
    output logic [BYTE_W-1:0]            o_byte,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic                         o_busy,
    output logic [$clog2(DEPTH+1)-1:0]   o_level,
    output logic                         o_overflow,
    input  logic                         i_clr_overflow
);

    ser_state_t          r_state;
    logic [BLOCK_W-1:0]  r_shift;
    logic [IDX_W-1:0]    r_byte_idx;
    logic                r_overflow;

    logic [BLOCK_W-1:0]  w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_last_acc;
    logic                w_pop;
    logic                w_drop;

    des_block_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (i_dv),
        .i_data  (i_block),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_level)
    );

    // Reloading on the last accepted byte keeps back-to-back blocks bubble-free.
    assign w_last_acc = (r_state == SHIFT) && i_ready &&
                        (r_byte_idx == IDX_W'(BYTES_PER_BLOCK - 1));
    assign w_pop      = !w_empty && ((r_state == IDLE) || w_last_acc);
    assign w_drop     = i_dv && w_full && !w_pop;

    assign o_valid    = (r_state == SHIFT);
    assign o_byte     = LSB_FIRST ? r_shift[BYTE_W-1:0] : r_shift[BLOCK_W-1 -: BYTE_W];
    assign o_busy     = !w_empty || (r_state != IDLE);
    assign o_overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_byte_idx <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clr_overflow) begin
                r_overflow <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_shift    <= w_head;
                        r_byte_idx <= '0;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (i_ready) begin
                        if (w_last_acc) begin
                            if (w_pop) begin
                                r_shift    <= w_head;
                                r_byte_idx <= '0;
                            end else begin
                                r_state    <= IDLE;
                            end
                        end else begin
                            r_shift    <= LSB_FIRST ? (r_shift >> BYTE_W) : (r_shift << BYTE_W);
                            r_byte_idx <= r_byte_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_des_out_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_des_out_serializer
// Description : Self-checking bench: directed scenarios plus random traffic vs a queue model.
// Revision    : 1.0
// ============================================================================
module tb_des_out_serializer;

    localparam int DEPTH = 2;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic [63:0]      i_block;
    logic             i_dv;
    logic [7:0]       o_byte;
    logic             o_valid;
    logic             i_ready;
    logic             o_busy;
    logic [LVL_W-1:0] o_level;
    logic             o_overflow;
    logic             i_clr_overflow;

    always #5 clk = ~clk;

    des_out_serializer #(
        .DEPTH     (DEPTH),
        .LSB_FIRST (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_block        (i_block),
        .i_dv           (i_dv),
        .o_byte         (o_byte),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_busy         (o_busy),
        .o_level        (o_level),
        .o_overflow     (o_overflow),
        .i_clr_overflow (i_clr_overflow)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference: queue of buffered blocks, queue of bytes still to send from the current block.
    logic [63:0] m_fifo [$];
    logic [7:0]  m_cur  [$];
    logic        m_ovf;
    logic [7:0]  got_bytes [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit          pop;
        logic [63:0] b;
        if (reset) begin
            m_fifo.delete();
            m_cur.delete();
            m_ovf = 1'b0;
            return;
        end
        pop = (m_fifo.size() > 0) && ((m_cur.size() == 0) || (i_ready && m_cur.size() == 1));
        if (m_cur.size() > 0 && i_ready) void'(m_cur.pop_front());
        if (pop) begin
            b = m_fifo.pop_front();
            for (int k = 0; k < 8; k++) m_cur.push_back(b[8*k +: 8]);
        end
        if (i_dv && m_fifo.size() >= DEPTH) m_ovf = 1'b1;
        else begin
            if (i_dv) m_fifo.push_back(i_block);
            if (i_clr_overflow) m_ovf = 1'b0;
        end
    endtask

    task automatic check_all();
        check_eq("valid", 64'(o_valid), 64'(m_cur.size() > 0));
        if (m_cur.size() > 0) check_eq("byte", 64'(o_byte), 64'(m_cur[0]));
        check_eq("level", 64'(o_level), 64'(m_fifo.size()));
        check_eq("busy", 64'(o_busy), 64'((m_fifo.size() > 0) || (m_cur.size() > 0)));
        check_eq("overflow", 64'(o_overflow), 64'(m_ovf));
    endtask

    task automatic step(input bit dv, input logic [63:0] blk, input bit rdy,
                        input bit clr, input bit rst);
        i_dv = dv; i_block = blk; i_ready = rdy; i_clr_overflow = clr; reset = rst;
        if (o_valid === 1'b1 && i_ready) got_bytes.push_back(o_byte);
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic check_stream(input string tag, input logic [63:0] blk0,
                                input logic [63:0] blk1, input int nblk);
        logic [63:0] b;
        check_eq({tag, "_count"}, 64'(got_bytes.size()), 64'(8 * nblk));
        for (int j = 0; j < nblk; j++) begin
            b = (j == 0) ? blk0 : blk1;
            for (int k = 0; k < 8; k++)
                if (got_bytes.size() > 8*j + k)
                    check_eq({tag, "_data"}, 64'(got_bytes[8*j + k]), 64'(b[8*k +: 8]));
        end
    endtask

    logic [63:0] blk_a, blk_b, blk_c;
    logic [7:0]  exp1 [8];
    int          peak, vcnt;

    initial begin
        blk_a = 64'h85E813540F0AB405;
        exp1  = '{8'h05, 8'hB4, 8'h0A, 8'h0F, 8'h54, 8'h13, 8'hE8, 8'h85};
        m_ovf = 1'b0;

        // Reset state
        step(0, 64'd0, 1, 0, 1);
        step(0, 64'd0, 1, 0, 1);
        check_eq("rst_byte", 64'(o_byte), 64'h0);
        step(0, 64'd0, 1, 0, 0);

        // Single block: latency and byte order from literal expectations
        got_bytes.delete();
        step(1, blk_a, 1, 0, 0);
        check_eq("lat_level_t1", 64'(o_level), 64'd1);
        step(0, 64'd0, 1, 0, 0);
        check_eq("lat_valid_t2", 64'(o_valid), 64'd1);
        check_eq("lat_byte0", 64'(o_byte), 64'h05);
        for (int i = 0; i < 10; i++) step(0, 64'd0, 1, 0, 0);
        check_eq("single_count", 64'(got_bytes.size()), 64'd8);
        for (int k = 0; k < 8; k++)
            if (got_bytes.size() > k) check_eq("single_byte", 64'(got_bytes[k]), 64'(exp1[k]));
        check_eq("single_idle_busy", 64'(o_busy), 64'd0);

        // Backpressure: ready pattern 1,0,0,1
        got_bytes.delete();
        step(1, blk_a, 1, 0, 0);
        for (int i = 0; i < 40; i++) step(0, 64'd0, (i % 4 == 0) || (i % 4 == 3), 0, 0);
        check_stream("bp", blk_a, blk_a, 1);

        // Back-to-back blocks, ready held high
        blk_a = 64'h1122334455667788;
        blk_b = 64'h99AABBCCDDEEFF00;
        got_bytes.delete();
        peak = 0; vcnt = 0;
        step(1, blk_a, 1, 0, 0);
        step(1, blk_b, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            if (int'(o_level) > peak) peak = int'(o_level);
            if (o_valid) vcnt++;
            step(0, 64'd0, 1, 0, 0);
        end
        check_stream("b2b", blk_a, blk_b, 2);
        check_eq("b2b_peak", 64'(peak), 64'd1);
        check_eq("b2b_valid_cycles", 64'(vcnt), 64'd16);

        // Overflow with consumer stalled
        got_bytes.delete();
        for (int i = 0; i < 4; i++) step(1, {$urandom, $urandom}, 0, 0, 0);
        step(0, 64'd0, 0, 0, 0);
        check_eq("ovf_level", 64'(o_level), 64'd2);
        check_eq("ovf_flag", 64'(o_overflow), 64'd1);
        for (int i = 0; i < 30; i++) step(0, 64'd0, 1, 0, 0);
        check_eq("ovf_bytes", 64'(got_bytes.size()), 64'd24);
        check_eq("ovf_sticky", 64'(o_overflow), 64'd1);
        step(0, 64'd0, 1, 1, 0);
        check_eq("ovf_clear", 64'(o_overflow), 64'd0);

        // Full FIFO with a push landing on the last-byte pop
        for (int i = 0; i < 3; i++) step(1, {$urandom, $urandom}, 0, 0, 0);
        step(0, 64'd0, 0, 0, 0);
        check_eq("full_level", 64'(o_level), 64'd2);
        for (int i = 0; i < 7; i++) step(0, 64'd0, 1, 0, 0);
        blk_c = {$urandom, $urandom};
        step(1, blk_c, 1, 0, 0);
        check_eq("full_pop_ovf", 64'(o_overflow), 64'd0);
        check_eq("full_pop_level", 64'(o_level), 64'd2);
        for (int i = 0; i < 30; i++) step(0, 64'd0, 1, 0, 0);

        // Reset mid-block, then a fresh block
        blk_a = {$urandom, $urandom};
        step(1, blk_a, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 64'd0, 1, 0, 0);
        step(1, blk_a, 1, 0, 1);
        check_eq("rst_mid_valid", 64'(o_valid), 64'd0);
        check_eq("rst_mid_level", 64'(o_level), 64'd0);
        check_eq("rst_mid_ovf", 64'(o_overflow), 64'd0);
        got_bytes.delete();
        blk_b = {$urandom, $urandom};
        step(1, blk_b, 1, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 64'd0, 1, 0, 0);
        check_stream("rst_fresh", blk_b, blk_b, 1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 2) == 0, {$urandom, $urandom}, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/des_out_serializer.md
# des_out_serializer

Downstream stage of the DES core wrapper. It captures each 64-bit result block on the core's one-cycle data-valid pulse and buffers it in a small block FIFO. It then streams the block out as eight bytes over a valid/ready byte interface, which feeds the chip's 8-bit IO output path. This decouples core throughput from a slower, backpressured off-chip byte consumer.

## Interface
Parameters:
- DEPTH, 2: number of 64-bit blocks buffered; power of two, ≥2.
- LSB_FIRST, 1: 1 = byte 0 is block[7:0]; 0 = byte 0 is block[63:56].

Ports:
- clk  input  1  clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- i_block  input  64  ciphertext/plaintext result from the DES core.
- i_dv  input  1  one-cycle pulse; i_block is valid this cycle.
- o_byte  output  8  current output byte.
- o_valid  output  1  o_byte is valid.
- i_ready  input  1  consumer accepts o_byte this cycle when o_valid=1.
- o_busy  output  1  FIFO non-empty or serializer not IDLE.
- o_level  output  $clog2(DEPTH+1)  number of blocks held in the FIFO, excluding the block being shifted.
- o_overflow  output  1  sticky flag: a block was dropped.
- i_clr_overflow  input  1  clears o_overflow.

## Operation
- Push: i_dv=1 writes i_block into the FIFO at the clock edge, if space is available.
- FIFO full is o_level==DEPTH. If the FIFO is full and no pop occurs in the same cycle:
  - the block is dropped;
  - o_overflow is set at that edge.
- Simultaneous push and pop at full: the pop frees a slot and the push is accepted. o_level is unchanged.
- Clearing overflow: i_clr_overflow=1 clears o_overflow. If a new drop occurs in the same cycle, set wins.
- The FSM has two states, IDLE and SHIFT.
- IDLE:
  - o_valid=0.
  - If the FIFO is non-empty: pop the head into the 64-bit shift register, set byte_idx=0, go to SHIFT.
- SHIFT:
  - o_valid=1. o_byte is the low byte of the shift register (LSB_FIRST=1) or the high byte (LSB_FIRST=0).
  - On o_valid && i_ready with byte_idx<7: shift by 8 bits toward the output byte, byte_idx++.
  - On o_valid && i_ready with byte_idx==7:
    - if the FIFO is non-empty, pop the head, reload the shift register, set byte_idx=0, and stay in SHIFT (no bubble);
    - otherwise go to IDLE.
- Handshake rule: while o_valid=1 and i_ready=0, o_byte and o_valid hold stable. o_valid never drops mid-block.
- byte_idx is 3 bits. The FIFO pointers are $clog2(DEPTH)+1 bits and wrap modulo 2·DEPTH.

## Timing
- Reset values: o_byte=0, o_valid=0, o_busy=0, o_level=0, o_overflow=0; FSM in IDLE; FIFO empty.
- Reset mid-block discards all buffered and in-flight data. o_valid drops the cycle after reset is sampled.
- Latency with an empty FIFO and FSM in IDLE: i_dv in cycle t, o_level=1 in cycle t+1, o_valid=1 with byte 0 in cycle t+2.
- Throughput with i_ready held at 1: one byte per cycle. Back-to-back blocks stream 8N bytes in 8N consecutive cycles.
- o_level is registered and reflects pushes and pops of the previous edge.
- o_busy is combinational from registered state.

## Structure
- Shared package des_io_pkg holds:
  - BLOCK_W=64, BYTE_W=8, BYTES_PER_BLOCK=8;
  - the serializer state enum {IDLE, SHIFT}.
- Sub-module des_block_fifo: a synchronous DEPTH×64 FIFO with push, pop, full, empty, level and wrapping pointers. The serializer FSM and the overflow logic stay in des_out_serializer.

## Test plan
- Single block, LSB_FIRST=1: i_block=64'h85E813540F0AB405 pulsed once with i_ready=1. Required response: o_valid rises 2 cycles later; bytes 05,B4,0A,0F,54,13,E8,85 appear on consecutive cycles; then o_valid=0 and o_busy=0.
- Backpressure: same block with i_ready toggling 1,0,0,1,… Required response: each byte is held stable while i_ready=0; the byte sequence is unchanged; no byte is duplicated or skipped.
- Back-to-back blocks: blocks A=64'h1122334455667788 and B=64'h99AABBCCDDEEFF00 pulsed in consecutive cycles with i_ready=1. Required response: 16 contiguous bytes 88..11 then 00..99 with no bubble; o_level peaks at 1.
- Overflow, DEPTH=2, i_ready=0: four pulses. Required response:
  - the first block is loaded into the shift register;
  - the second and third are buffered, o_level=2;
  - the fourth is dropped and o_overflow=1;
  - after releasing i_ready, exactly 24 bytes are output;
  - i_clr_overflow then clears the flag.
- Full plus simultaneous pop: with the FIFO full and the last byte accepted, pulse i_dv in that same cycle. Required response: the block is accepted, o_overflow stays 0, o_level stays 2.
- Reset mid-block: assert reset after 3 bytes. Required response: next cycle o_valid=0, o_level=0, o_overflow=0; a fresh block afterwards streams correctly starting at byte 0.
